// File: rtl/line_burst_rd_responder.sv
// Line-refill read responder: accepts one line-aligned request, waits ACCESS_LAT cycles,
// then streams BURST_LEN words from a 1-cycle-latency SRAM through a 2-entry output FIFO.
module line_burst_rd_responder #(
  parameter int BURST_LEN  = 8,
  parameter int SRAM_AW    = 12,
  parameter int ACCESS_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req_valid,
  input  logic [31:0]        rd_req_addr,
  output logic               rd_req_ready,
  output logic               rd_rsp_valid,
  output logic [31:0]        rd_rsp_data,
  output logic               rd_rsp_last,
  input  logic               rd_rsp_ready,
  output logic               sram_ren,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_rdata
);

  localparam int LB = $clog2(BURST_LEN);
  localparam int IW = LB + 1;
  localparam int LW = (ACCESS_LAT > 0) ? $clog2(ACCESS_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t              r_state;
  logic [SRAM_AW-LB-1:0] r_line;
  logic [IW-1:0]       r_issue_cnt;
  logic [LB-1:0]       r_out_cnt;
  logic [LW-1:0]       r_lat_cnt;
  logic                r_inflight;
  logic [31:0]         r_fifo [2];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_fifo_cnt;

  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic [2:0]          w_occ;
  logic                w_ren;
  logic                w_unused;

  assign rd_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept     = rd_req_valid && rd_req_ready;
  assign rd_rsp_valid = (r_fifo_cnt != 2'd0);
  assign rd_rsp_data  = r_fifo[r_rd_ptr];
  assign rd_rsp_last  = rd_rsp_valid && (r_out_cnt == LB'(BURST_LEN - 1));
  assign w_pop        = rd_rsp_valid && rd_rsp_ready;
  assign w_push       = r_inflight;

  // Credit: buffered beats plus the read in flight, after this cycle's pop, must leave a slot.
  assign w_occ     = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_ren     = !rst && (r_state == S_STREAM) && !r_issue_cnt[LB] && (w_occ < 3'd2);
  assign sram_ren  = w_ren;
  assign sram_addr = {r_line, r_issue_cnt[LB-1:0]};

  assign w_unused = ^{rd_req_addr[31:SRAM_AW+2], rd_req_addr[LB+1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_line      <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_lat_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      r_inflight <= w_ren;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_ren) begin
        r_issue_cnt <= r_issue_cnt + IW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_out_cnt <= r_out_cnt + LB'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line      <= rd_req_addr[SRAM_AW+1:LB+2];
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_lat_cnt   <= LW'(ACCESS_LAT);
            r_state     <= (ACCESS_LAT > 0) ? S_WAIT : S_STREAM;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - LW'(1);
          if (r_lat_cnt <= LW'(1)) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_pop && rd_rsp_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage is plain data; occupancy and pointers above decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wr_ptr] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_line_burst_rd_responder.sv
// Scoreboard bench: the request driver queues the expected line read from a SRAM image,
// a negedge monitor pops and compares every accepted beat and checks handshake timing.
module tb_line_burst_rd_responder;

  localparam int BL  = 8;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req_valid = 1'b0;
  logic [31:0]   rd_req_addr = 32'd0;
  logic          rd_req_ready;
  logic          rd_rsp_valid;
  logic [31:0]   rd_rsp_data;
  logic          rd_rsp_last;
  logic          rd_rsp_ready = 1'b1;
  logic          sram_ren;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  logic [31:0] mem [1 << AW];

  line_burst_rd_responder #(.BURST_LEN(BL), .SRAM_AW(AW), .ACCESS_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_last(rd_rsp_last),
    .rd_rsp_ready(rd_rsp_ready),
    .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_addr];

  typedef struct { logic [31:0] d; logic l; } beat_t;
  beat_t exp_q[$];

  int total = 0, bad = 0, cyc = 0;
  int acc_cyc = 0, occ = 0, rdy_mode = 0, ph = 0;
  bit busy = 0, first_seen = 1, stalled = 0, hold_v = 0, post_rst = 0, prev_rst = 0;
  logic [31:0] hd;
  logic hl;

  initial forever begin #5 clk = ~clk; if (clk) cyc++; end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, req);
    end
  endtask

  // Reference: the request names a word; the line is that word rounded down to BL words.
  task automatic expect_burst(input logic [31:0] addr);
    int w, base;
    w    = int'((addr >> 2) % (1 << AW));
    base = w - (w % BL);
    for (int i = 0; i < BL; i++) exp_q.push_back('{mem[base + i], (i == BL - 1)});
  endtask

  // Response-side ready pattern, changed just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: rd_rsp_ready = 1'b1;
      1: begin rd_rsp_ready = (ph == 0); ph = (ph + 1) % 3; end
      default: rd_rsp_ready = ($urandom_range(3) != 0);
    endcase
  end

  // Monitor: everything is sampled at the falling edge, where handshakes for the next rise are settled.
  always @(negedge clk) begin
    if (rst) begin
      chk(!rd_req_ready, "ready_in_reset", 32'(rd_req_ready), 32'd0);
      if (prev_rst)
        chk(!rd_rsp_valid && !rd_rsp_last && !sram_ren, "reset_outputs",
            {29'd0, rd_rsp_valid, rd_rsp_last, sram_ren}, 32'd0);
      exp_q.delete();
      busy = 0; occ = 0; hold_v = 0; post_rst = 1; first_seen = 1; prev_rst = 1;
    end else begin
      prev_rst = 0;
      if (post_rst) begin
        chk(!rd_rsp_valid && !sram_ren, "after_reset_idle", {30'd0, rd_rsp_valid, sram_ren}, 32'd0);
        post_rst = 0;
      end
      chk(rd_req_ready == !busy, "req_ready", 32'(rd_req_ready), 32'(!busy));
      if (hold_v)
        chk(rd_rsp_valid && rd_rsp_data == hd && rd_rsp_last == hl, "stall_hold", rd_rsp_data, hd);
      hold_v = rd_rsp_valid && !rd_rsp_ready;
      hd = rd_rsp_data;
      hl = rd_rsp_last;
      if (hold_v) stalled = 1;
      if (rd_rsp_valid && !first_seen) begin
        chk(cyc - acc_cyc == LAT + 3, "first_beat_cycle", 32'(cyc - acc_cyc), 32'(LAT + 3));
        first_seen = 1;
      end
      occ = occ + int'(sram_ren) - int'(rd_rsp_valid && rd_rsp_ready);
      chk(occ <= 2, "buffer_occupancy", 32'(occ), 32'd2);
      if (rd_rsp_valid && rd_rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", rd_rsp_data, 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk(rd_rsp_data == e.d, "beat_data", rd_rsp_data, e.d);
          chk(rd_rsp_last == e.l, "beat_last", 32'(rd_rsp_last), 32'(e.l));
          if (e.l) begin
            if (!stalled)
              chk(cyc - acc_cyc == LAT + 2 + BL, "last_beat_cycle", 32'(cyc - acc_cyc), 32'(LAT + 2 + BL));
            busy = 0;
          end
        end
      end
      if (rd_req_valid && rd_req_ready) begin
        expect_burst(rd_req_addr);
        busy = 1; acc_cyc = cyc; first_seen = 0; stalled = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic [31:0] a, input bit keep);
    int n = 0;
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    do begin @(negedge clk); n++; end while (!rd_req_ready && n < 300);
    if (!rd_req_ready) chk(1'b0, "request_timeout", a, 32'd0);
    @(posedge clk); #1;
    if (!keep) rd_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < 500);
    if (busy) chk(1'b0, "burst_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int w = 0; w < (1 << AW); w++) mem[w] = 32'(w);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    send(32'h0000_0040, 1'b0); wait_idle();
    send(32'h0000_005C, 1'b0); wait_idle();
    send(32'h8000_0040, 1'b0); wait_idle();

    rdy_mode = 1; ph = 0;
    send(32'h0000_0040, 1'b0); wait_idle();
    rdy_mode = 0;

    send(32'h0000_0000, 1'b1);
    send(32'h0000_0020, 1'b0);
    wait_idle();

    send(32'h0000_0040, 1'b0);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (exp_q.size() > BL - 2 && n < 100);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send(32'h0000_0080, 1'b0); wait_idle();

    for (int w = 0; w < (1 << AW); w++) mem[w] = $urandom;
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      send($urandom, 1'b0);
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
